core_stack: RTL and testbench
=============================

Name: core_stack

Overview:
- LIFO return/data stack directly downstream of the CORE stack strobes.
- Stores return addresses on CALL, data words on PUSH, and segment values on GET_SA/SB/SC.
- Returns the top entry on RET, POP and SET_SA/SB/SC.
- Single-cycle push/pop, so the CORE IP machine can consume the popped address in the same cycle as the strobe.

Parameters:
- DATA_W, 8, width of data, IP and segment words.
- DEPTH, 16, number of entries; must be a power of two, at least 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, never overridden.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- push  in  1  push strobe (CORE stack_read_data).
- pop  in  1  pop strobe (CORE stack_write_data).
- push_sel  in  2  push source: 0 data_in, 1 ip_in, 2 seg_in, 3 reserved (treated as 0).
- data_in  in  DATA_W  word from data bus (PUSH).
- ip_in  in  DATA_W  return address (CALL).
- seg_in  in  DATA_W  segment value (GET_Sx).
- pop_data  out  DATA_W  top-of-stack, valid while pop=1, else 0.
- pop_valid  out  1  pop=1 and stack not empty.
- sp  out  PTR_W+1  current entry count, 0..DEPTH.
- full  out  1  sp==DEPTH.
- empty  out  1  sp==0.
- ovf  out  1  sticky overflow.
- unf  out  1  sticky underflow.
- err_clr  in  1  synchronous clear of ovf/unf.

Behaviour:
- Reset (async, RESET=0):
  - sp=0, ovf=0, unf=0.
  - Array contents are don't-care; pop_data is 0 because the stack is empty.
  - A reset during any operation aborts it; the next edge after release starts from empty.
- Storage: mem[0..DEPTH-1]. Entry at index sp-1 is the top.
- Push source mux is combinational: push_sel 1 → ip_in, 2 → seg_in, else data_in.
- Pop read path is combinational (zero latency):
  - pop_data = mem[sp-1] when pop && !empty; otherwise 0.
  - CORE registers it on the same edge that retires the pop.
- Push only (push=1, pop=0, !full): mem[sp] <= src; sp <= sp+1 at the edge.
- Pop only (pop=1, push=0, !empty): sp <= sp-1 at the edge.
- Push and pop in the same cycle (replace):
  - Not empty: pop_data = old top; mem[sp-1] <= src; sp unchanged.
  - Empty: pop is an underflow (unf <= 1, pop_data=0); push proceeds normally (sp <= 1).
- Push when full (without pop): write dropped, sp unchanged, ovf <= 1.
- Pop when empty (without push): pop_data=0, pop_valid=0, sp stays 0, unf <= 1.
- No wrap-around: sp saturates at 0 and DEPTH.
- Error flags:
  - ovf and unf stay set until err_clr=1 at an edge.
  - If err_clr and a new error occur in the same cycle, the flag is set (set wins).
- full, empty and pop_valid are combinational from sp and pop.
- No state machine beyond the sp counter.

Optional Feature:
- Macro: CORE_STACK_FLAGS_EN.
- When defined:
  - Adds ports flags_in (in, 2: {cf,zf}), flags_save (in, 1: CORE FLAG_read_data) and flags_out (out, 2).
  - Every entry widens to DATA_W+2.
  - A push with flags_save=1 stores flags_in with the word; other pushes store 2'b00.
  - flags_out = stored flags of the popped entry while pop && !empty, else 0.
- When undefined: ports and extra bits are absent; entry width is DATA_W.

Decomposition:
- Shared package core_stack_pkg:
  - push_sel encodings: PSEL_DATA=0, PSEL_IP=1, PSEL_SEG=2.
  - Flag-field width constant: 2.
- One sub-module, core_stack_ram:
  - DEPTH x width array, synchronous write, asynchronous read, no reset on contents.
- Pointer, error logic and source mux stay in core_stack.

Test Plan:
- Reset then CALL: push=1, push_sel=1, ip_in=0x23. Next cycle pop=1 → pop_data=0x23, pop_valid=1. After the edge: sp=0, empty=1.
- Order: push data_in 0x11, 0x22, 0x33 (sel 0). Three pops → 0x33, 0x22, 0x11. A fourth pop → pop_data=0, unf=1, sp=0.
- Overflow: 16 pushes of 0x00..0x0F → full=1. Push 0xAA → ovf=1, sp=16. Pop → 0x0F.
- Replace: stack {0x05}; push=pop=1, push_sel=2, seg_in=0x3C → pop_data=0x05, sp stays 1. Next pop → 0x3C.
- Error clear and set priority:
  - With unf=1: err_clr=1 → unf=0.
  - err_clr=1 with a simultaneous pop on empty → unf=1.
- Async reset mid-stream: sp=5, drop RESET between edges → sp=0, empty=1 immediately. Pop after release → pop_data=0.
- (CORE_STACK_FLAGS_EN) Push ip 0x40 with flags_save=1, flags_in=2'b10. Pop → flags_out=2'b10, pop_data=0x40.

Source files
------------

// File: rtl/core_stack_pkg.sv
// core_stack shared definitions: push source encodings and flag field width.
// Optional feature macro: CORE_STACK_FLAGS_EN (flag bits stored per entry).
package core_stack_pkg;

    typedef enum logic [1:0] {
        PSEL_DATA = 2'd0,
        PSEL_IP   = 2'd1,
        PSEL_SEG  = 2'd2,
        PSEL_RSVD = 2'd3
    } psel_e;

    localparam int FLAG_W = 2;

endpackage

// File: rtl/core_stack_if.sv
// core_stack bus: push/pop strobes, sources, pop result, status, error clear.
// Ports: master = CORE side, slave = stack. CORE_STACK_FLAGS_EN adds flags.
interface core_stack_if
    import core_stack_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PTR_W  = 4
);
    logic              push;
    logic              pop;
    logic [1:0]        push_sel;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] ip_in;
    logic [DATA_W-1:0] seg_in;
    logic [DATA_W-1:0] pop_data;
    logic              pop_valid;
    logic [PTR_W:0]    sp;
    logic              full;
    logic              empty;
    logic              ovf;
    logic              unf;
    logic              err_clr;
`ifdef CORE_STACK_FLAGS_EN
    logic [FLAG_W-1:0] flags_in;
    logic              flags_save;
    logic [FLAG_W-1:0] flags_out;
`endif

    modport master (
        output push, pop, push_sel, data_in, ip_in, seg_in, err_clr,
`ifdef CORE_STACK_FLAGS_EN
        output flags_in, flags_save,
        input  flags_out,
`endif
        input  pop_data, pop_valid, sp, full, empty, ovf, unf
    );

    modport slave (
        input  push, pop, push_sel, data_in, ip_in, seg_in, err_clr,
`ifdef CORE_STACK_FLAGS_EN
        input  flags_in, flags_save,
        output flags_out,
`endif
        output pop_data, pop_valid, sp, full, empty, ovf, unf
    );

endinterface

// File: rtl/core_stack_ram.sv
// core_stack storage: DEPTH x W array, synchronous write, asynchronous read.
// Ports: CLK, we/waddr/wdata write port, raddr/rdata combinational read port.
module core_stack_ram #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Contents carry no reset: the pointer alone defines what is valid.
    always_ff @(posedge CLK) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/core_stack.sv
// core_stack: LIFO return/data/segment stack with zero-latency pop.
// Ports: CLK, RESET (async, active low), bus (core_stack_if.slave).
// Macro CORE_STACK_FLAGS_EN stores {cf,zf} alongside each entry.
module core_stack
    import core_stack_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic         CLK,
    input  logic         RESET,
    core_stack_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int SP_W  = PTR_W + 1;
`ifdef CORE_STACK_FLAGS_EN
    localparam int ENT_W = DATA_W + FLAG_W;
`else
    localparam int ENT_W = DATA_W;
`endif
    localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);

    logic [SP_W-1:0]   sp_q, sp_d;
    logic              ovf_q, unf_q;
    logic              full, empty;
    logic              ovf_set, unf_set;
    logic              pop_ok;
    logic              we;
    logic [PTR_W-1:0]  top_idx;
    logic [PTR_W-1:0]  waddr;
    logic [DATA_W-1:0] src;
    logic [ENT_W-1:0]  wdata;
    logic [ENT_W-1:0]  rdata;

    assign full    = (sp_q == SP_FULL);
    assign empty   = (sp_q == '0);
    assign pop_ok  = bus.pop && !empty;
    assign top_idx = PTR_W'(sp_q - SP_ONE);

    always_comb begin
        src = bus.data_in;
        case (bus.push_sel)
            PSEL_IP:  src = bus.ip_in;
            PSEL_SEG: src = bus.seg_in;
            default:  src = bus.data_in;
        endcase
    end

`ifdef CORE_STACK_FLAGS_EN
    assign wdata = {(bus.flags_save ? bus.flags_in : '0), src};
`else
    assign wdata = src;
`endif

    // A replace (push with a successful pop) overwrites the top in place
    // and is allowed even when full; a plain push needs a free slot.
    assign we      = bus.push && (pop_ok || !full);
    assign waddr   = pop_ok ? top_idx : sp_q[PTR_W-1:0];
    assign ovf_set = bus.push && !bus.pop && full;
    assign unf_set = bus.pop && empty;

    always_comb begin
        sp_d = sp_q;
        if (bus.push && !pop_ok) begin
            if (!full) sp_d = sp_q + SP_ONE;
        end else if (pop_ok && !bus.push) begin
            sp_d = sp_q - SP_ONE;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            ovf_q <= ovf_set || (ovf_q && !bus.err_clr);
            unf_q <= unf_set || (unf_q && !bus.err_clr);
        end
    end

    core_stack_ram #(
        .W     (ENT_W),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_ram (
        .CLK   (CLK),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (top_idx),
        .rdata (rdata)
    );

    assign bus.pop_data  = pop_ok ? rdata[DATA_W-1:0] : '0;
    assign bus.pop_valid = pop_ok;
    assign bus.sp        = sp_q;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.ovf       = ovf_q;
    assign bus.unf       = unf_q;
`ifdef CORE_STACK_FLAGS_EN
    assign bus.flags_out = pop_ok ? rdata[DATA_W +: FLAG_W] : '0;
`endif

endmodule

// File: tb/tb_core_stack.sv
// Self-checking bench for core_stack: directed vectors, pop results
// checked by a monitor against a queue of expected responses.
module tb_core_stack;
    import core_stack_pkg::*;

    localparam int DW = 8;
    localparam int DP = 16;
    localparam int PW = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic          valid;
        logic [1:0]    flags;
    } exp_t;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    logic       tb_fsave = 1'b0;
    logic [1:0] tb_fin = 2'b00;
    logic [1:0] tb_expf = 2'b00;

    core_stack_if #(.DATA_W(DW), .PTR_W(PW)) bus ();

    core_stack #(.DATA_W(DW), .DEPTH(DP)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every cycle with pop asserted consumes one expectation.
    always @(negedge CLK) begin
        if (RESET && bus.pop) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pop_data", int'(bus.pop_data), int'(e.data));
                check("pop_valid", int'(bus.pop_valid), int'(e.valid));
`ifdef CORE_STACK_FLAGS_EN
                check("flags_out", int'(bus.flags_out), int'(e.flags));
`endif
            end
        end
    end

    // One cycle of stimulus; the selected source carries val, others junk.
    task automatic step(input logic pu, input logic po,
                        input logic [1:0] sel, input logic [DW-1:0] val,
                        input logic clr, input logic [DW-1:0] exp_d,
                        input logic exp_v);
        exp_t e;
        bus.push     = pu;
        bus.pop      = po;
        bus.push_sel = sel;
        bus.err_clr  = clr;
        bus.data_in  = (sel == PSEL_DATA || sel == PSEL_RSVD) ? val : 8'hD1;
        bus.ip_in    = (sel == PSEL_IP)  ? val : 8'hE2;
        bus.seg_in   = (sel == PSEL_SEG) ? val : 8'hF3;
`ifdef CORE_STACK_FLAGS_EN
        bus.flags_save = tb_fsave;
        bus.flags_in   = tb_fin;
`endif
        if (po) begin
            e.data  = exp_d;
            e.valid = exp_v;
            e.flags = tb_expf;
            exp_q.push_back(e);
        end
        @(posedge CLK);
        #1;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.err_clr = 1'b0;
    endtask

    task automatic push_v(input logic [1:0] sel, input logic [DW-1:0] v);
        step(1'b1, 1'b0, sel, v, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic pop_v(input logic [DW-1:0] d, input logic v);
        step(1'b0, 1'b1, PSEL_DATA, 8'h00, 1'b0, d, v);
    endtask

    initial begin
        bus.push = 1'b0;
        bus.pop = 1'b0;
        bus.push_sel = 2'd0;
        bus.data_in = '0;
        bus.ip_in = '0;
        bus.seg_in = '0;
        bus.err_clr = 1'b0;
`ifdef CORE_STACK_FLAGS_EN
        bus.flags_save = 1'b0;
        bus.flags_in = 2'b00;
`endif
        #12;
        check("rst_sp", int'(bus.sp), 0);
        check("rst_empty", int'(bus.empty), 1);
        check("rst_full", int'(bus.full), 0);
        check("rst_ovf", int'(bus.ovf), 0);
        check("rst_unf", int'(bus.unf), 0);
        check("rst_pop_data", int'(bus.pop_data), 0);
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;

        // CALL then RET
        push_v(PSEL_IP, 8'h23);
        check("call_sp", int'(bus.sp), 1);
        pop_v(8'h23, 1'b1);
        check("ret_sp", int'(bus.sp), 0);
        check("ret_empty", int'(bus.empty), 1);

        // LIFO order, then underflow
        push_v(PSEL_DATA, 8'h11);
        push_v(PSEL_DATA, 8'h22);
        push_v(PSEL_DATA, 8'h33);
        check("order_sp", int'(bus.sp), 3);
        pop_v(8'h33, 1'b1);
        pop_v(8'h22, 1'b1);
        pop_v(8'h11, 1'b1);
        check("order_unf_pre", int'(bus.unf), 0);
        pop_v(8'h00, 1'b0);
        check("unf_set", int'(bus.unf), 1);
        check("unf_sp", int'(bus.sp), 0);

        // Error clear, then set-wins priority
        step(1'b0, 1'b0, PSEL_DATA, 8'h00, 1'b1, 8'h00, 1'b0);
        check("unf_clr", int'(bus.unf), 0);
        step(1'b0, 1'b1, PSEL_DATA, 8'h00, 1'b1, 8'h00, 1'b0);
        check("unf_set_wins", int'(bus.unf), 1);
        step(1'b0, 1'b0, PSEL_DATA, 8'h00, 1'b1, 8'h00, 1'b0);

        // Overflow
        for (int i = 0; i < DP; i++) push_v(PSEL_DATA, 8'(i));
        check("ovf_full", int'(bus.full), 1);
        check("ovf_sp16", int'(bus.sp), 16);
        check("ovf_pre", int'(bus.ovf), 0);
        push_v(PSEL_DATA, 8'hAA);
        check("ovf_set", int'(bus.ovf), 1);
        check("ovf_sp", int'(bus.sp), 16);
        pop_v(8'h0F, 1'b1);
        check("ovf_pop_sp", int'(bus.sp), 15);
        check("ovf_sticky", int'(bus.ovf), 1);

        // Async reset mid-stream
        RESET = 1'b0;
        #2;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        for (int i = 0; i < 5; i++) push_v(PSEL_SEG, 8'(8'h50 + i));
        check("ar_sp5", int'(bus.sp), 5);
        #2;
        RESET = 1'b0;
        #1;
        check("ar_sp", int'(bus.sp), 0);
        check("ar_empty", int'(bus.empty), 1);
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        pop_v(8'h00, 1'b0);
        check("ar_pop_sp", int'(bus.sp), 0);
        step(1'b0, 1'b0, PSEL_DATA, 8'h00, 1'b1, 8'h00, 1'b0);

        // Replace
        push_v(PSEL_DATA, 8'h05);
        step(1'b1, 1'b1, PSEL_SEG, 8'h3C, 1'b0, 8'h05, 1'b1);
        check("repl_sp", int'(bus.sp), 1);
        pop_v(8'h3C, 1'b1);
        check("repl_empty", int'(bus.empty), 1);

        // Replace on empty: underflow, push still lands
        step(1'b1, 1'b1, PSEL_IP, 8'h6B, 1'b0, 8'h00, 1'b0);
        check("repl_e_unf", int'(bus.unf), 1);
        check("repl_e_sp", int'(bus.sp), 1);
        pop_v(8'h6B, 1'b1);

        // Reserved select reads data_in
        push_v(PSEL_RSVD, 8'h77);
        pop_v(8'h77, 1'b1);

`ifdef CORE_STACK_FLAGS_EN
        tb_fsave = 1'b1;
        tb_fin = 2'b10;
        push_v(PSEL_IP, 8'h40);
        tb_fsave = 1'b0;
        tb_fin = 2'b11;
        push_v(PSEL_DATA, 8'h41);
        tb_expf = 2'b00;
        pop_v(8'h41, 1'b1);
        tb_expf = 2'b10;
        pop_v(8'h40, 1'b1);
        tb_expf = 2'b00;
`endif

        @(negedge CLK);
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
